// File: rtl/sprite_pkg.sv
// Types and screen constants shared by the sprite scheduler and the renderer.
package sprite_pkg;

   localparam int SCREEN_W_DEFAULT = 640;
   localparam int SCREEN_H_DEFAULT = 480;

   typedef struct packed {
      logic [7:0]  id;
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  scale;
   } sprite_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      ISSUE     = 3'd2,
      WAIT_DONE = 3'd3,
      POP       = 3'd4,
      GAP       = 3'd5
   } sched_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sprite_scheduler.sv
// Per-frame walker over the sprite queue: skip off-screen heads, issue draws,
// wait for completion under a watchdog, then pop with a clean one-cycle pulse.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int MAX_SPRITES = 8,
   parameter int SCREEN_W    = SCREEN_W_DEFAULT,
   parameter int SCREEN_H    = SCREEN_H_DEFAULT,
   parameter int TIMEOUT     = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        is_empty,
   input  logic [7:0]  sprite_id,
   input  logic [15:0] sprite_x,
   input  logic [15:0] sprite_y,
   input  logic [7:0]  sprite_scale,
   output logic        dequeue,
   output logic        draw_valid,
   input  logic        draw_ready,
   output logic [7:0]  draw_id,
   output logic [15:0] draw_x,
   output logic [15:0] draw_y,
   output logic [7:0]  draw_scale,
   input  logic        draw_done,
   output logic        frame_busy,
   output logic [7:0]  sprite_count,
   output logic [7:0]  skip_count,
   output logic        frame_overrun,
   output logic        budget_hit,
   output logic        timeout_err,
   output logic [2:0]  state
);

   localparam int          WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [7:0]  BUDGET  = 8'(MAX_SPRITES);
   localparam logic [15:0] X_LIM   = 16'(SCREEN_W);
   localparam logic [15:0] Y_LIM   = 16'(SCREEN_H);

   sched_state_t    cur;
   sprite_t         cmd;
   logic [WD_W-1:0] watchdog;

   // Valid/ready: a command transfers on the cycle where draw_valid && draw_ready;
   // draw_* are driven from a register and never change while draw_valid is high.
   assign draw_id    = cmd.id;
   assign draw_x     = cmd.x;
   assign draw_y     = cmd.y;
   assign draw_scale = cmd.scale;
   assign state      = cur;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur           <= IDLE;
         cmd           <= '0;
         watchdog      <= '0;
         dequeue       <= 1'b0;
         draw_valid    <= 1'b0;
         frame_busy    <= 1'b0;
         sprite_count  <= 8'd0;
         skip_count    <= 8'd0;
         frame_overrun <= 1'b0;
         budget_hit    <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         budget_hit    <= 1'b0;
         timeout_err   <= 1'b0;
         frame_overrun <= frame_start && (cur != IDLE);
         case (cur)
            IDLE: begin
               if (frame_start) begin
                  sprite_count <= 8'd0;
                  skip_count   <= 8'd0;
                  frame_busy   <= 1'b1;
                  cur          <= FETCH;
               end
            end
            FETCH: begin
               if (is_empty) begin
                  frame_busy <= 1'b0;
                  cur        <= IDLE;
               end else if (sprite_count == BUDGET) begin
                  budget_hit <= 1'b1;
                  frame_busy <= 1'b0;
                  cur        <= IDLE;
               end else if (sprite_x >= X_LIM || sprite_y >= Y_LIM) begin
                  skip_count <= sat_inc(skip_count);
                  dequeue    <= 1'b1;
                  cur        <= POP;
               end else begin
                  cmd        <= '{id: sprite_id, x: sprite_x, y: sprite_y, scale: sprite_scale};
                  draw_valid <= 1'b1;
                  cur        <= ISSUE;
               end
            end
            ISSUE: begin
               if (draw_ready) begin
                  draw_valid <= 1'b0;
                  watchdog   <= '0;
                  cur        <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (draw_done) begin
                  sprite_count <= sat_inc(sprite_count);
                  dequeue      <= 1'b1;
                  cur          <= POP;
               end else if (watchdog == WD_LAST) begin
                  // Abandoned sprite is popped but not counted toward the budget.
                  timeout_err <= 1'b1;
                  dequeue     <= 1'b1;
                  cur         <= POP;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            POP: begin
               dequeue <= 1'b0;
               cur     <= GAP;
            end
            GAP: begin
               cur <= FETCH;
            end
            default: begin
               cur <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a behavioural queue, a renderer model
// and a scoreboard that checks every accepted draw command in order.
module tb_sprite_scheduler;
   import sprite_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        is_empty;
   logic [7:0]  sprite_id;
   logic [15:0] sprite_x;
   logic [15:0] sprite_y;
   logic [7:0]  sprite_scale;
   logic        dequeue;
   logic        draw_valid;
   logic        draw_ready = 1'b1;
   logic [7:0]  draw_id;
   logic [15:0] draw_x;
   logic [15:0] draw_y;
   logic [7:0]  draw_scale;
   logic        draw_done = 1'b0;
   logic        frame_busy;
   logic [7:0]  sprite_count;
   logic [7:0]  skip_count;
   logic        frame_overrun;
   logic        budget_hit;
   logic        timeout_err;
   logic [2:0]  state;

   sprite_scheduler dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .is_empty(is_empty),
      .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_scale(sprite_scale),
      .dequeue(dequeue), .draw_valid(draw_valid), .draw_ready(draw_ready),
      .draw_id(draw_id), .draw_x(draw_x), .draw_y(draw_y), .draw_scale(draw_scale),
      .draw_done(draw_done), .frame_busy(frame_busy), .sprite_count(sprite_count),
      .skip_count(skip_count), .frame_overrun(frame_overrun), .budget_hit(budget_hit),
      .timeout_err(timeout_err), .state(state)
   );

   // Clock / reset
   initial forever #5 clock = ~clock;

   initial begin
      #900000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

   // Queue model and renderer knobs
   sprite_t     q_mem [64];
   logic [7:0]  q_head = 8'd0;
   logic [7:0]  q_tail = 8'd0;
   logic        q_flush = 1'b0;
   int          stall_req = 0;
   int          done_delay = 5;
   logic        force_done = 1'b0;

   assign is_empty     = (q_head == q_tail);
   assign sprite_id    = q_mem[q_head[5:0]].id;
   assign sprite_x     = q_mem[q_head[5:0]].x;
   assign sprite_y     = q_mem[q_head[5:0]].y;
   assign sprite_scale = q_mem[q_head[5:0]].scale;

   // Scoreboard and statistics
   logic [47:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cycle = 0;
   int deq_edges = 0, accepts = 0, valid_cycles = 0;
   int n_budget = 0, n_timeout = 0, n_overrun = 0;
   int accept_cycle = 0, timeout_cycle = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   wire [47:0] cur_cmd = {draw_id, draw_x, draw_y, draw_scale};

   // Monitor, queue pop and renderer, all acting on the falling edge
   initial begin
      logic        deq_prev = 1'b0, budget_prev = 1'b0, timeout_prev = 1'b0, overrun_prev = 1'b0;
      logic        hold_valid = 1'b0;
      logic [47:0] held_cmd = '0;
      logic [47:0] e;
      int          stalled = 0;
      int          done_timer = 0;
      forever begin
         @(negedge clock);
         cycle++;
         if (q_flush) q_head = q_tail;
         else if (dequeue && !deq_prev && q_head != q_tail) q_head = q_head + 8'd1;
         if (dequeue) begin
            if (!deq_prev) deq_edges++;
            check("dequeue_one_cycle", deq_prev, 0);
         end
         if (budget_hit)    begin n_budget++;  check("budget_one_cycle", budget_prev, 0); end
         if (timeout_err)   begin n_timeout++; timeout_cycle = cycle; check("timeout_one_cycle", timeout_prev, 0); end
         if (frame_overrun) begin n_overrun++; check("overrun_one_cycle", overrun_prev, 0); end
         deq_prev = dequeue; budget_prev = budget_hit;
         timeout_prev = timeout_err; overrun_prev = frame_overrun;

         draw_done = force_done;
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) draw_done = 1'b1;
         end
         if (draw_valid && stalled < stall_req) begin
            draw_ready = 1'b0;
            stalled++;
         end else begin
            draw_ready = 1'b1;
         end
         if (hold_valid && draw_valid) check("draw_stable", cur_cmd, held_cmd);
         hold_valid = draw_valid && !draw_ready;
         held_cmd   = cur_cmd;
         if (draw_valid) valid_cycles++;
         if (draw_valid && draw_ready) begin
            accepts++;
            accept_cycle = cycle;
            stalled = 0;
            if (done_delay > 0) done_timer = done_delay;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL draw_cmd: got id %0d expected no draw", draw_id);
            end else begin
               e = exp_q.pop_front();
               check("draw_cmd", cur_cmd, e);
            end
         end
      end
   end

   // Driver tasks
   task automatic push(input int id, input int x, input int y, input int scale, input bit drawn);
      sprite_t s;
      s = '{id: 8'(id), x: 16'(x), y: 16'(y), scale: 8'(scale)};
      q_mem[q_tail[5:0]] = s;
      q_tail = q_tail + 8'd1;
      if (drawn) exp_q.push_back(s);
   endtask

   task automatic start_frame();
      @(negedge clock); frame_start = 1'b1;
      @(negedge clock); frame_start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!(state == IDLE && !frame_busy) && n < bound) begin
         @(negedge clock); n++;
      end
      check("wait_idle_in_budget", (n < bound), 1);
   endtask

   task automatic wait_state(input logic [2:0] st, input int bound);
      int n = 0;
      while (state != st && n < bound) begin
         @(negedge clock); n++;
      end
      check("wait_state_in_budget", (n < bound), 1);
   endtask

   task automatic flush();
      @(negedge clock); q_flush = 1'b1;
      repeat (2) @(negedge clock);
      q_flush = 1'b0;
   endtask

   // Directed sequence
   initial begin
      int d0, a0, v0, b0, t0, o0;
      foreach (q_mem[i]) q_mem[i] = '0;
      repeat (3) @(negedge clock);
      check("reset_state", state, IDLE);
      check("reset_ctrl", {dequeue, draw_valid, frame_busy, budget_hit, timeout_err, frame_overrun}, 0);
      check("reset_cmd", cur_cmd, 0);
      check("reset_counts", {sprite_count, skip_count}, 0);
      reset = 1'b0;

      // Two drawable sprites, done 5 cycles after accept
      push(1, 200, 200, 0, 1);
      push(3, 300, 300, 1, 1);
      d0 = deq_edges;
      @(negedge clock); frame_start = 1'b1;
      @(negedge clock); frame_start = 1'b0;
      check("busy_at_t1", frame_busy, 1);
      @(negedge clock);
      check("valid_at_t2", draw_valid, 1);
      wait_idle(200);
      check("two_sprite_count", sprite_count, 2);
      check("two_skip_count", skip_count, 0);
      check("two_dequeues", deq_edges - d0, 2);
      check("two_scoreboard_empty", exp_q.size(), 0);

      // Skips: x=700, y=480 and x=640 boundaries; y=479 drawn
      push(5, 700, 10, 0, 0);
      push(6, 10, 480, 0, 0);
      push(7, 10, 479, 2, 1);
      push(8, 640, 0, 0, 0);
      d0 = deq_edges; a0 = accepts;
      start_frame();
      wait_idle(200);
      check("skip_count", skip_count, 3);
      check("skip_sprite_count", sprite_count, 1);
      check("skip_dequeues", deq_edges - d0, 4);
      check("skip_accepts", accepts - a0, 1);

      // Budget: 10 drawable sprites, 8 drawn
      done_delay = 1;
      for (int i = 0; i < 10; i++) push(20 + i, 16 * i, 8 * i, i, i < 8);
      b0 = n_budget;
      start_frame();
      wait_idle(400);
      check("budget_sprite_count", sprite_count, 8);
      check("budget_pulse", n_budget - b0, 1);
      check("budget_left_in_queue", q_tail - q_head, 2);
      check("budget_scoreboard_empty", exp_q.size(), 0);
      flush();

      // Ready held low 20 cycles, then no done: watchdog abort
      stall_req = 20; done_delay = 0;
      push(9, 100, 100, 3, 1);
      d0 = deq_edges; v0 = valid_cycles; t0 = n_timeout;
      start_frame();
      wait_idle(5000);
      check("stall_valid_cycles", valid_cycles - v0, 21);
      check("timeout_pulse", n_timeout - t0, 1);
      check("timeout_latency", timeout_cycle - accept_cycle, 4097);
      check("timeout_sprite_count", sprite_count, 0);
      check("timeout_dequeue", deq_edges - d0, 1);
      stall_req = 0;

      // frame_start during WAIT_DONE
      done_delay = 20;
      push(10, 50, 50, 0, 1);
      o0 = n_overrun;
      start_frame();
      wait_state(WAIT_DONE, 20);
      @(negedge clock); frame_start = 1'b1;
      @(negedge clock); frame_start = 1'b0;
      check("overrun_pulse_high", frame_overrun, 1);
      @(negedge clock);
      check("overrun_pulse_low", frame_overrun, 0);
      check("overrun_frame_continues", frame_busy, 1);
      wait_idle(200);
      check("overrun_count", n_overrun - o0, 1);
      check("overrun_sprite_count", sprite_count, 1);

      // Reset during ISSUE, then a stray draw_done
      stall_req = 100; done_delay = 5;
      push(11, 20, 20, 0, 0);
      start_frame();
      wait_state(ISSUE, 20);
      d0 = deq_edges;
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      check("midreset_state", state, IDLE);
      check("midreset_ctrl", {dequeue, draw_valid, frame_busy, budget_hit, timeout_err, frame_overrun}, 0);
      check("midreset_cmd", cur_cmd, 0);
      check("midreset_counts", {sprite_count, skip_count}, 0);
      reset = 1'b0; stall_req = 0; force_done = 1'b1;
      repeat (2) @(negedge clock);
      force_done = 1'b0;
      repeat (4) @(negedge clock);
      check("late_done_state", state, IDLE);
      check("late_done_count", sprite_count, 0);
      check("midreset_no_dequeue", deq_edges - d0, 0);
      check("midreset_queue_kept", q_tail - q_head, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-frame sequencer between `sprite_queue` and the sprite renderer. On each frame start it walks the queue head. For each sprite it either skips it (off-screen) or issues one draw command via a valid/ready handshake, then waits for the renderer's completion. After that it pops the queue with a clean dequeue pulse. It enforces a per-frame sprite budget and a per-sprite render watchdog, and reports frame statistics to the control logic.

## Interface
- `MAX_SPRITES`, 8: sprites drawn per frame before the budget stop.
- `SCREEN_W`, 640: x at or above this value is off-screen.
- `SCREEN_H`, 480: y at or above this value is off-screen.
- `TIMEOUT`, 4096: cycles allowed in WAIT_DONE before abort.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse at vblank.
- `is_empty` in 1: queue empty flag.
- `sprite_id` in 8: queue head id.
- `sprite_x` in 16: queue head x.
- `sprite_y` in 16: queue head y.
- `sprite_scale` in 8: queue head scale.
- `dequeue` out 1: pop request to the queue. The queue acts on the rising edge only.
- `draw_valid` out 1: draw command valid.
- `draw_ready` in 1: renderer accepts the command.
- `draw_id` out 8: latched command field.
- `draw_x` out 16: latched command field.
- `draw_y` out 16: latched command field.
- `draw_scale` out 8: latched command field.
- `draw_done` in 1: one-cycle pulse when the accepted sprite is finished.
- `frame_busy` out 1: high from frame accept until DONE.
- `sprite_count` out 8: sprites drawn this frame, saturating at 255.
- `skip_count` out 8: sprites skipped this frame, saturating at 255.
- `frame_overrun` out 1: one-cycle pulse.
- `budget_hit` out 1: one-cycle pulse.
- `timeout_err` out 1: one-cycle pulse.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_DONE, POP, GAP.
- IDLE: on `frame_start`, clear both counters, raise `frame_busy`, go to FETCH.
- FETCH, checked in priority order:
  - `is_empty` → IDLE and drop `frame_busy`.
  - `sprite_count == MAX_SPRITES` → pulse `budget_hit`, then IDLE.
  - `sprite_x >= SCREEN_W` or `sprite_y >= SCREEN_H` (unsigned 16-bit compare) → increment `skip_count`, go to POP.
  - Otherwise latch the head into `draw_*` and go to ISSUE.
- ISSUE: `draw_valid` is high.
  - When `draw_ready` is seen, drop `draw_valid`, clear the watchdog, go to WAIT_DONE.
  - `draw_*` holds stable while valid and not accepted.
- WAIT_DONE:
  - `draw_done` → increment `sprite_count`, go to POP.
  - Watchdog reaches `TIMEOUT-1` → pulse `timeout_err`, go to POP. The sprite is not counted.
- POP: `dequeue=1` for exactly one cycle, then GAP.
- GAP: `dequeue=0` for one cycle, so the queue sees a fresh edge and the head/`is_empty` update has settled. Then FETCH.
- `frame_start` outside IDLE: pulse `frame_overrun`. The current frame continues; the pulse is not queued.
- `draw_done` outside WAIT_DONE is ignored.
- `draw_ready` outside ISSUE is ignored.
- Counters saturate at 255. Budget is compared on `sprite_count` only; skipped sprites do not consume budget.

## Timing
- Reset: state IDLE. All outputs are 0: `dequeue`, `draw_valid`, `draw_*`, `frame_busy`, both counters, and all pulses.
- Reset mid-frame aborts immediately. The queue is not popped and the next state is IDLE.
- `frame_start` at cycle t → `frame_busy` at t+1 (FETCH) → `draw_valid` at t+2 when the head is drawable.
- Handshake completes in the cycle where `draw_valid && draw_ready`.
- `draw_done` at cycle d → `dequeue` at d+1, GAP at d+2, FETCH at d+3.
- Skip path: FETCH → POP → GAP → FETCH, 3 cycles per skipped sprite.
- Counters update the cycle after the qualifying event.
- Pulse outputs are registered, one cycle each.

## Structure
- Shared package `sprite_pkg`:
  - `sprite_t` struct (id 8, x 16, y 16, scale 8).
  - `sched_state_t` enum.
  - Default `SCREEN_W`/`SCREEN_H` constants, also used by the renderer.
- Single module with no sub-modules.
- Watchdog width is `$clog2(TIMEOUT)`.

## Test plan
- Two sprites queued, (1,200,200,0) and (3,300,300,1); renderer has ready=1 and done 5 cycles after accept.
  - Expect two draws in order, two dequeue pulses separated by ≥1 low cycle.
  - Expect `sprite_count=2`, then `frame_busy` drops.
- Head at x=700 → no `draw_valid`, one dequeue, `skip_count=1`.
- Head at y=480 (boundary) → skipped.
- Head at y=479 → drawn.
- 10 drawable sprites with `MAX_SPRITES=8` → 8 draws, then `budget_hit` pulse, IDLE with 2 sprites remaining in the queue.
- Renderer with `draw_ready` held low for 20 cycles → `draw_*` stable throughout. Then `draw_done` is never sent → `timeout_err` after `TIMEOUT` cycles, dequeue, `sprite_count` unchanged.
- `frame_start` during WAIT_DONE → `frame_overrun` pulse, frame continues.
- `reset` asserted during ISSUE → next cycle IDLE, all outputs 0, no dequeue; a late `draw_done` is ignored.
